// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encodings and defaults.
package fetch_unit_pkg;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE  = 2'd0;
  localparam fetch_state_t ST_REQ   = 2'd1;
  localparam fetch_state_t ST_HOLD  = 2'd2;
  localparam fetch_state_t ST_DRAIN = 2'd3;

  // sll $0,$0,0
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

  // Fetch addresses are always word aligned; low two bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit_watchdog.sv
// Counts consecutive cycles an imem request goes unanswered and raises a sticky error.
module fetch_unit_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic nrst,
  input  logic count_en,
  output logic imem_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_cnt_d;

  // Next count: saturating increment while waiting, otherwise back to zero.
  always_comb begin
    wait_cnt_d = '0;
    if (count_en) begin
      wait_cnt_d = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + CW'(1);
    end
  end

  // Counter register and sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wait_cnt <= '0;
      imem_err <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_d;
      if (wait_cnt_d == CNT_MAX) begin
        imem_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to imem, feeds the IF/ID register.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | one quiet cycle after reset release, no request
// ST_REQ   | request at pc outstanding; response bypassed straight out
// ST_HOLD  | stalled; fetched word parked in buffer, no request
// ST_DRAIN | redirect abandoned a pending request; wait it out, then
//          | fetch from the new pc
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT,
  parameter int          TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                stall,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  fetch_unit_if.master        bus,
  output logic [31:0]         pc_IF,
  output logic [31:0]         IF_pc4,
  output logic [31:0]         IF_inst,
  output logic                if_valid,
  output logic                imem_err
);

  fetch_state_t state, state_d;
  logic [31:0]  pc, pc_d;
  logic [31:0]  drain_addr, drain_addr_d;
  logic [31:0]  buffer, buffer_d;
  logic [31:0]  redirect_tgt;
  logic         rvalid;
  logic         wd_count;

  assign redirect_tgt = word_align(redirect_pc);
  assign rvalid       = bus.imem_rvalid;

  // Next-state logic; redirect wins over both stall and an arriving response.
  always_comb begin
    state_d      = state;
    pc_d         = pc;
    drain_addr_d = drain_addr;
    buffer_d     = buffer;
    case (state)
      ST_IDLE: begin
        if (redirect) pc_d = redirect_tgt;
        else          state_d = ST_REQ;
      end
      ST_REQ: begin
        if (redirect) begin
          pc_d = redirect_tgt;
          if (!rvalid) begin
            // The old request is still in flight; keep its address on the bus.
            drain_addr_d = pc;
            state_d      = ST_DRAIN;
          end
        end else if (rvalid) begin
          if (stall) begin
            buffer_d = bus.imem_rdata;
            state_d  = ST_HOLD;
          end else begin
            pc_d = pc + 32'd4;
          end
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          pc_d     = redirect_tgt;
          buffer_d = NOP_INST;
          state_d  = ST_REQ;
        end else if (!stall) begin
          pc_d    = pc + 32'd4;
          state_d = ST_REQ;
        end
      end
      ST_DRAIN: begin
        if (redirect) pc_d = redirect_tgt;
        // Once the abandoned request completes there is nothing left to wait for.
        if (rvalid) state_d = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, pc and data registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= ST_IDLE;
      pc         <= RESET_PC;
      drain_addr <= RESET_PC;
      buffer     <= NOP_INST;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      drain_addr <= drain_addr_d;
      buffer     <= buffer_d;
    end
  end

  // Output muxing from the current state and the live imem response.
  always_comb begin
    bus.imem_req  = (state == ST_REQ) || (state == ST_DRAIN);
    bus.imem_addr = (state == ST_DRAIN) ? drain_addr : pc;
    if_valid      = !redirect && (((state == ST_REQ) && rvalid) || (state == ST_HOLD));
    if (!if_valid)               IF_inst = NOP_INST;
    else if (state == ST_HOLD)   IF_inst = buffer;
    else                         IF_inst = bus.imem_rdata;
    pc_IF  = pc;
    IF_pc4 = pc + 32'd4;
  end

  // A wait cycle only counts while the same request stays pending in the same state.
  assign wd_count = ((state == ST_REQ) || (state == ST_DRAIN)) && !rvalid && (state_d == state);

  fetch_unit_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .nrst     (nrst),
    .count_en (wd_count),
    .imem_err (imem_err)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: configurable-latency imem, cycle model, directed scenarios.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk;
  logic        nrst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc_IF, IF_pc4, IF_inst;
  logic        if_valid, imem_err;

  fetch_unit_if bus();

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .NOP_INST (32'h0000_0000),
    .TIMEOUT  (16)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus),
    .pc_IF       (pc_IF),
    .IF_pc4      (IF_pc4),
    .IF_inst     (IF_inst),
    .if_valid    (if_valid),
    .imem_err    (imem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- imem model ----------------
  // lat = cycles from request to response inclusive (1 = same cycle), 0 = never answers.
  int lat;
  bit const_mode;
  bit rv_force;
  int mem_cnt;

  function automatic logic [31:0] mem_word(input bit cm, input logic [31:0] a);
    return cm ? 32'h2008_0005 : (a ^ 32'hC0DE_0000);
  endfunction

  always_comb begin
    bus.imem_rvalid = rv_force || (bus.imem_req && (lat != 0) && (mem_cnt >= lat - 1));
    bus.imem_rdata  = mem_word(const_mode, bus.imem_addr);
  end

  always @(posedge clk or negedge nrst) begin
    if (!nrst)                                  mem_cnt <= 0;
    else if (bus.imem_req && !bus.imem_rvalid)  mem_cnt <= mem_cnt + 1;
    else                                        mem_cnt <= 0;
  end

  // ---------------- reference model ----------------
  bit          m_starting, m_holding, m_draining, m_err;
  logic [31:0] m_pc, m_drain_addr, m_hold_word;
  int          m_wait;

  always @(negedge clk) begin
    logic        rv, e_req, e_valid, waiting;
    logic [31:0] e_inst, tgt;
    rv = bus.imem_rvalid;
    if (!nrst) begin
      chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
      chk("rst_valid", {31'd0, if_valid}, 32'd0);
      chk("rst_inst", IF_inst, NOP);
      chk("rst_pc", pc_IF, 32'h0);
      chk("rst_pc4", IF_pc4, 32'h4);
      chk("rst_err", {31'd0, imem_err}, 32'd0);
      m_starting = 1; m_holding = 0; m_draining = 0; m_err = 0;
      m_pc = 32'h0; m_drain_addr = 32'h0; m_hold_word = NOP; m_wait = 0;
    end else begin
      e_req   = !m_starting && !m_holding;
      e_valid = 0;
      if (m_holding) e_valid = !redirect;
      else if (!m_starting && !m_draining) e_valid = rv && !redirect;
      e_inst = !e_valid ? NOP : (m_holding ? m_hold_word : mem_word(const_mode, m_pc));
      chk("model_req", {31'd0, bus.imem_req}, {31'd0, e_req});
      if (e_req) chk("model_addr", bus.imem_addr, m_draining ? m_drain_addr : m_pc);
      chk("model_valid", {31'd0, if_valid}, {31'd0, e_valid});
      chk("model_inst", IF_inst, e_inst);
      chk("model_pc", pc_IF, m_pc);
      chk("model_pc4", IF_pc4, m_pc + 32'd4);
      chk("model_err", {31'd0, imem_err}, {31'd0, m_err});

      // one request stuck waiting, not being abandoned this cycle
      waiting = e_req && !rv && !(!m_draining && redirect);
      m_wait  = waiting ? ((m_wait < 16) ? m_wait + 1 : 16) : 0;
      if (m_wait == 16) m_err = 1;

      tgt = redirect_pc & ~32'h3;
      if (m_starting) begin
        if (redirect) m_pc = tgt; else m_starting = 0;
      end else if (m_holding) begin
        if (redirect) begin m_pc = tgt; m_holding = 0; end
        else if (!stall) begin m_pc = m_pc + 32'd4; m_holding = 0; end
      end else if (m_draining) begin
        if (redirect) m_pc = tgt;
        if (rv) m_draining = 0;
      end else begin
        if (redirect) begin
          if (!rv) begin m_draining = 1; m_drain_addr = m_pc; end
          m_pc = tgt;
        end else if (rv) begin
          if (stall) begin m_holding = 1; m_hold_word = mem_word(const_mode, m_pc); end
          else m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int nvalid, early;
    bit found;
    nrst = 0; stall = 0; redirect = 0; redirect_pc = 32'h0;
    lat = 1; const_mode = 1; rv_force = 0;
    next_cycle();
    next_cycle();
    chk("lit_rst_pc4", IF_pc4, 32'h4);
    chk("lit_rst_inst", IF_inst, NOP);
    nrst = 1;

    // zero-wait memory: IDLE then one instruction per cycle
    @(negedge clk);
    chk("lit_idle_valid", {31'd0, if_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("lit_zw_pc", pc_IF, 32'(i * 4));
      chk("lit_zw_pc4", IF_pc4, 32'(i * 4 + 4));
      chk("lit_zw_inst", IF_inst, 32'h2008_0005);
    end

    // 3-cycle latency: one valid per three cycles, address held while waiting
    next_cycle();
    lat = 3; const_mode = 0;
    nvalid = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      nvalid += int'(if_valid);
      if (i < 2) chk("lit_lat_addr", bus.imem_addr, 32'h10);
    end
    chk("lit_lat_count", 32'(nvalid), 32'd2);

    // stall for four cycles on the instruction at 0x10
    next_cycle();
    lat = 1; redirect = 1; redirect_pc = 32'h10;
    next_cycle();
    redirect = 0; stall = 1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (if_valid) found = 1;
    end
    chk("lit_stall_found", {31'd0, found}, 32'd1);
    chk("lit_stall_pc", pc_IF, 32'h10);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lit_hold_pc", pc_IF, 32'h10);
      chk("lit_hold_inst", IF_inst, 32'hC0DE_0010);
      chk("lit_hold_req", {31'd0, bus.imem_req}, 32'd0);
    end
    next_cycle();
    stall = 0;
    @(negedge clk);
    @(negedge clk);
    chk("lit_after_hold_addr", bus.imem_addr, 32'h14);

    // redirect while the 0x08 request is outstanding -> drain, then fetch 0x40
    next_cycle();
    nrst = 0; lat = 3;
    next_cycle();
    nrst = 1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.imem_req && bus.imem_addr == 32'h8) found = 1;
    end
    chk("lit_req8_found", {31'd0, found}, 32'd1);
    next_cycle();
    redirect = 1; redirect_pc = 32'h43;
    @(negedge clk);
    chk("lit_redir_valid", {31'd0, if_valid}, 32'd0);
    next_cycle();
    redirect = 0;
    @(negedge clk);
    chk("lit_drain_addr", bus.imem_addr, 32'h8);
    chk("lit_drain_valid", {31'd0, if_valid}, 32'd0);
    chk("lit_drain_inst", IF_inst, NOP);
    @(negedge clk);
    chk("lit_target_addr", bus.imem_addr, 32'h40);

    // redirect and stall together while holding -> flush
    next_cycle();
    lat = 1; stall = 1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (!bus.imem_req && if_valid) found = 1;
    end
    chk("lit_hold2_found", {31'd0, found}, 32'd1);
    next_cycle();
    redirect = 1; redirect_pc = 32'h80;
    @(negedge clk);
    chk("lit_flush_valid", {31'd0, if_valid}, 32'd0);
    chk("lit_flush_inst", IF_inst, NOP);
    next_cycle();
    redirect = 0; stall = 0;
    @(negedge clk);
    chk("lit_flush_pc", pc_IF, 32'h80);
    chk("lit_flush_new_inst", IF_inst, 32'hC0DE_0080);

    // PC wrap, then a memory that never answers -> watchdog
    next_cycle();
    redirect = 1; redirect_pc = 32'hFFFF_FFFC;
    next_cycle();
    redirect = 0;
    @(negedge clk);
    chk("lit_wrap_pc", pc_IF, 32'hFFFF_FFFC);
    chk("lit_wrap_pc4", IF_pc4, 32'h0);
    @(negedge clk);
    chk("lit_wrapped_pc", pc_IF, 32'h0);
    chk("lit_wrapped_valid", {31'd0, if_valid}, 32'd1);
    next_cycle();
    lat = 0;
    early = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      early += int'(imem_err);
    end
    chk("lit_err_early", 32'(early), 32'd0);
    chk("lit_wait_addr", bus.imem_addr, 32'h4);
    @(negedge clk);
    chk("lit_err_set", {31'd0, imem_err}, 32'd1);
    repeat (3) @(negedge clk);
    chk("lit_err_sticky", {31'd0, imem_err}, 32'd1);
    chk("lit_err_still_req", {31'd0, bus.imem_req}, 32'd1);
    next_cycle();
    nrst = 0;
    #1;
    chk("lit_err_cleared", {31'd0, imem_err}, 32'd0);

    // stray response while IDLE is ignored
    next_cycle();
    rv_force = 1;
    nrst = 1;
    @(negedge clk);
    chk("lit_idle_rv_valid", {31'd0, if_valid}, 32'd0);
    next_cycle();
    rv_force = 0;
    @(negedge clk);
    chk("lit_idle_rv_req", {31'd0, bus.imem_req}, 32'd1);
    chk("lit_idle_rv_addr", bus.imem_addr, 32'h0);

    next_cycle();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
